updown_counter_param: RTL and testbench

UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_next.sv | 106 ++++++++++
 rtl/updown_counter_param.sv | 67 ++++++
 tb/tb_updown_counter_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the parameterised up/down counter: mode encodings and direction values.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count, next-direction and boundary-pulse logic for updown_counter_param.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned        WIDTH   = 5,
  parameter logic [WIDTH-1:0]   MIN_VAL = '0,
  parameter logic [WIDTH-1:0]   MAX_VAL = '1
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  input  logic             en_i,
  input  logic             ctrl_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_d_c,
  output logic             dir_d_c,
  output logic             tc_d_c
);

  // One guard bit so +1 past the top of the range is visible rather than wrapping.
  localparam int unsigned      AW      = WIDTH + 1;
  localparam logic [AW-1:0]    MIN_EXT = {1'b0, MIN_VAL};
  localparam logic [AW-1:0]    MAX_EXT = {1'b0, MAX_VAL};

  logic [AW-1:0] cnt_ext;
  logic [AW-1:0] inc_ext;
  logic [AW-1:0] dec_ext;
  logic [AW-1:0] ld_ext;
  mode_e         mode_s;

  assign cnt_ext = {1'b0, count_i};
  assign inc_ext = cnt_ext + AW'(1);
  assign dec_ext = cnt_ext - AW'(1);
  assign ld_ext  = {1'b0, load_val_i};
  assign mode_s  = mode_e'(mode_i);

  always_comb begin
    count_d_c = count_i;
    dir_d_c   = dir_i;
    tc_d_c    = 1'b0;
    if (clr_i) begin
      count_d_c = MIN_VAL;
      dir_d_c   = DIR_UP;
    end else if (load_i) begin
      if (ld_ext < MIN_EXT)      count_d_c = MIN_VAL;
      else if (ld_ext > MAX_EXT) count_d_c = MAX_VAL;
      else                       count_d_c = load_val_i;
    end else if (en_i) begin
      case (mode_s)
        MODE_SAT: begin
          dir_d_c = ctrl_i;
          if (ctrl_i) begin
            if (cnt_ext < MAX_EXT) begin
              count_d_c = WIDTH'(inc_ext);
              tc_d_c    = (inc_ext == MAX_EXT);
            end
          end else if (cnt_ext > MIN_EXT) begin
            count_d_c = WIDTH'(dec_ext);
            tc_d_c    = (dec_ext == MIN_EXT);
          end
        end
        MODE_BOUNCE: begin
          // Sitting on a bound (e.g. after load) just steps away without a pulse.
          if (cnt_ext >= MAX_EXT) begin
            count_d_c = WIDTH'(dec_ext);
            dir_d_c   = DIR_DOWN;
          end else if (cnt_ext <= MIN_EXT) begin
            count_d_c = WIDTH'(inc_ext);
            dir_d_c   = DIR_UP;
          end else if (dir_i == DIR_UP) begin
            count_d_c = WIDTH'(inc_ext);
            if (inc_ext == MAX_EXT) begin
              dir_d_c = DIR_DOWN;
              tc_d_c  = 1'b1;
            end
          end else begin
            count_d_c = WIDTH'(dec_ext);
            if (dec_ext == MIN_EXT) begin
              dir_d_c = DIR_UP;
              tc_d_c  = 1'b1;
            end
          end
        end
        default: begin
          dir_d_c = ctrl_i;
          if (ctrl_i) begin
            if (inc_ext > MAX_EXT) begin
              count_d_c = MIN_VAL;
              tc_d_c    = 1'b1;
            end else begin
              count_d_c = WIDTH'(inc_ext);
            end
          end else if (cnt_ext <= MIN_EXT) begin
            count_d_c = MAX_VAL;
            tc_d_c    = 1'b1;
          end else begin
            count_d_c = WIDTH'(dec_ext);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Bounded up/down counter with wrap, saturate and bounce modes; holds the count/dir/tc registers.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int unsigned        WIDTH   = 5,
  parameter logic [WIDTH-1:0]   MIN_VAL = '0,
  parameter logic [WIDTH-1:0]   MAX_VAL = '1
) (
  input  logic             clkout,
  input  logic             rst,
  input  logic             en,
  input  logic             ctrl,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             dir_q;
  logic             dir_d;
  logic             tc_q;
  logic             tc_d;

  counter_next #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count_i    (count_q),
    .dir_i      (dir_q),
    .en_i       (en),
    .ctrl_i     (ctrl),
    .mode_i     (mode),
    .clr_i      (clr),
    .load_i     (load),
    .load_val_i (load_val),
    .count_d_c  (count_d),
    .dir_d_c    (dir_d),
    .tc_d_c     (tc_d)
  );

  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      count_q <= MIN_VAL;
      dir_q   <= DIR_UP;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign count  = count_q;
  assign dir    = dir_q;
  assign tc     = tc_q;
  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == MIN_VAL);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: two counter instances (full 0..31 range and 3..10 range) against an integer model.
module tb_updown_counter_param;

  typedef struct {
    int cnt;
    bit dir;
    bit tc;
  } st_t;

  logic       clkout   = 1'b0;
  logic       rst      = 1'b1;
  logic       en       = 1'b0;
  logic       ctrl     = 1'b0;
  logic [1:0] mode     = 2'b00;
  logic       clr      = 1'b0;
  logic       load     = 1'b0;
  logic [4:0] load_val = 5'd0;

  logic [4:0] count_a, count_b;
  logic       dir_a, dir_b, tc_a, tc_b, at_max_a, at_max_b, at_min_a, at_min_b;

  int  checks   = 0;
  int  failures = 0;
  bit  chk_en   = 1'b0;
  st_t ma = '{0, 1'b1, 1'b0};
  st_t mb = '{3, 1'b1, 1'b0};

  updown_counter_param dut_a (
    .clkout(clkout), .rst(rst), .en(en), .ctrl(ctrl), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val), .count(count_a), .dir(dir_a), .tc(tc_a),
    .at_max(at_max_a), .at_min(at_min_a)
  );

  updown_counter_param #(.WIDTH(5), .MIN_VAL(5'd3), .MAX_VAL(5'd10)) dut_b (
    .clkout(clkout), .rst(rst), .en(en), .ctrl(ctrl), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val), .count(count_b), .dir(dir_b), .tc(tc_b),
    .at_max(at_max_b), .at_min(at_min_b)
  );

  always #5 clkout = ~clkout;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Reference behaviour: wrap uses modular arithmetic over the range, sat clamps, bounce reflects.
  function automatic st_t step(input st_t s, input int mn, input int mx, input bit en_v,
                               input bit ctrl_v, input bit [1:0] mode_v, input bit clr_v,
                               input bit load_v, input int lv);
    st_t r;
    int  span;
    int  target;
    span = mx - mn + 1;
    r    = s;
    r.tc = 1'b0;
    if (clr_v) begin
      r.cnt = mn;
      r.dir = 1'b1;
    end else if (load_v) begin
      r.cnt = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
    end else if (en_v) begin
      if (mode_v == 2'b10) begin
        if (s.cnt == mx) begin
          r.cnt = mx - 1; r.dir = 1'b0;
        end else if (s.cnt == mn) begin
          r.cnt = mn + 1; r.dir = 1'b1;
        end else begin
          r.cnt = s.dir ? s.cnt + 1 : s.cnt - 1;
          r.tc  = (r.cnt == mx) || (r.cnt == mn);
          r.dir = (r.cnt == mx) ? 1'b0 : ((r.cnt == mn) ? 1'b1 : s.dir);
        end
      end else if (mode_v == 2'b01) begin
        r.dir  = ctrl_v;
        target = ctrl_v ? mx : mn;
        if (s.cnt != target) begin
          r.cnt = s.cnt + (ctrl_v ? 1 : -1);
          r.tc  = (r.cnt == target);
        end
      end else begin
        r.dir = ctrl_v;
        r.cnt = mn + ((s.cnt - mn + (ctrl_v ? 1 : span - 1)) % span);
        r.tc  = ctrl_v ? (s.cnt == mx) : (s.cnt == mn);
      end
    end
    return r;
  endfunction

  always @(posedge clkout or negedge rst) begin
    if (!rst) begin
      ma <= '{0, 1'b1, 1'b0};
      mb <= '{3, 1'b1, 1'b0};
    end else begin
      ma <= step(ma, 0, 31, en, ctrl, mode, clr, load, int'(load_val));
      mb <= step(mb, 3, 10, en, ctrl, mode, clr, load, int'(load_val));
    end
  end

  // Every cycle both instances must match the model on all outputs.
  always @(negedge clkout) begin
    if (chk_en) begin
      chk("a.count", int'(count_a), ma.cnt);
      chk("a.dir", int'(dir_a), int'(ma.dir));
      chk("a.tc", int'(tc_a), int'(ma.tc));
      chk("a.at_max", int'(at_max_a), int'(ma.cnt == 31));
      chk("a.at_min", int'(at_min_a), int'(ma.cnt == 0));
      chk("b.count", int'(count_b), mb.cnt);
      chk("b.dir", int'(dir_b), int'(mb.dir));
      chk("b.tc", int'(tc_b), int'(mb.tc));
      chk("b.at_max", int'(at_max_b), int'(mb.cnt == 10));
      chk("b.at_min", int'(at_min_b), int'(mb.cnt == 3));
    end
  end

  task automatic step_edge();
    @(posedge clkout);
    #1;
  endtask

  int exp35[5] = '{9, 10, 10, 10, 10};

  initial begin
    #2 rst = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset.a.count", int'(count_a), 0);
    chk("reset.a.dir", int'(dir_a), 1);
    chk("reset.a.tc", int'(tc_a), 0);
    chk("reset.a.at_min", int'(at_min_a), 1);
    chk("reset.b.count", int'(count_b), 3);
    step_edge();
    step_edge();

    // Wrap up through the full range.
    rst = 1'b1; mode = 2'b00; ctrl = 1'b1; en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step_edge();
      chk("wrap_up.count", int'(count_a), (i + 1) % 32);
      chk("wrap_up.tc", int'(tc_a), int'(i == 31));
    end

    // Wrap down straight out of reset.
    rst = 1'b0;
    #1 chk("rst_async.count", int'(count_a), 0);
    rst = 1'b1; ctrl = 1'b0;
    step_edge();
    chk("wrap_down.a.count", int'(count_a), 31);
    chk("wrap_down.a.tc", int'(tc_a), 1);
    chk("wrap_down.b.count", int'(count_b), 10);
    chk("wrap_down.b.tc", int'(tc_b), 1);

    // Async reset mid-count.
    rst = 1'b0; #1 rst = 1'b1; ctrl = 1'b1;
    repeat (7) step_edge();
    chk("mid_rst.pre", int'(count_a), 7);
    #3 rst = 1'b0;
    #1 chk("mid_rst.count", int'(count_a), 0);
    chk("mid_rst.dir", int'(dir_a), 1);
    step_edge();
    chk("mid_rst.held", int'(count_a), 0);
    rst = 1'b1;
    step_edge();
    chk("mid_rst.resume", int'(count_a), 1);

    // Saturate after load.
    mode = 2'b01; ctrl = 1'b1; load = 1'b1; load_val = 5'd8;
    step_edge();
    chk("sat.load", int'(count_b), 8);
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step_edge();
      chk("sat.count", int'(count_b), exp35[k]);
      chk("sat.tc", int'(tc_b), int'(k == 1));
    end

    // Bounce from reset over 3..10.
    rst = 1'b0; #1 rst = 1'b1; mode = 2'b10; en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step_edge();
      chk("bounce.count", int'(count_b), (k <= 7) ? 3 + k : ((k <= 14) ? 10 - (k - 7) : 4));
      chk("bounce.tc", int'(tc_b), int'(k == 7 || k == 14));
      chk("bounce.dir", int'(dir_b), int'(!(k >= 7 && k < 14)));
    end

    // Load clamp, clr over load, enable hold.
    load = 1'b1; load_val = 5'd31;
    step_edge();
    chk("clamp.b", int'(count_b), 10);
    chk("clamp.a", int'(count_a), 31);
    clr = 1'b1;
    step_edge();
    chk("clr_load.a", int'(count_a), 0);
    chk("clr_load.b", int'(count_b), 3);
    clr = 1'b0; load_val = 5'd6;
    step_edge();
    load = 1'b0; en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step_edge();
      chk("hold.count", int'(count_b), 6);
      chk("hold.tc", int'(tc_b), 0);
    end

    // Bounce starting on the upper bound steps away quietly.
    en = 1'b1; load = 1'b1; load_val = 5'd10;
    step_edge();
    chk("bound.load", int'(count_b), 10);
    load = 1'b0;
    step_edge();
    chk("bound.count", int'(count_b), 9);
    chk("bound.dir", int'(dir_b), 0);
    chk("bound.tc", int'(tc_b), 0);

    // Random traffic, model compare runs every cycle.
    for (int n = 0; n < 3000; n++) begin
      clr      = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      ctrl     = 1'($urandom_range(0, 1));
      load_val = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        #1 chk("rand_rst.a", int'(count_a), 0);
        chk("rand_rst.b", int'(count_b), 3);
        rst = 1'b1;
      end
      step_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
